// File: rtl/wall_clock_pkg.sv
// Shared encodings and field geometry for the wall-clock time-setting path.
package wall_clock_pkg;

  // Set-mode states double as the externally visible mode code.
  typedef enum logic [1:0] {
    MODE_RUN   = 2'd0,
    MODE_SET_H = 2'd1,
    MODE_SET_M = 2'd2,
    MODE_SET_S = 2'd3
  } mode_e;

  // Bit offsets of each two-digit BCD field inside the 24-bit time word.
  localparam int HOURS_LSB   = 16;
  localparam int MINUTES_LSB = 8;
  localparam int SECONDS_LSB = 0;

  // Field limits, numeric and as packed BCD for direct comparison.
  localparam int HOURS_MAX   = 23;
  localparam int MIN_SEC_MAX = 59;
  localparam logic [7:0] HOURS_MAX_BCD   = 8'h23;
  localparam logic [7:0] MIN_SEC_MAX_BCD = 8'h59;

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes one raw button and emits a single-cycle pulse on an accepted press.
module button_debouncer
  import wall_clock_pkg::*;
#(
  parameter int STABLE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic button_raw,
  output logic press
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  logic [1:0]    sync_q;
  logic          level_q;
  logic [CW-1:0] cnt_q;

  // Two-flop synchronizer for the asynchronous button input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b00;
    else          sync_q <= {sync_q[0], button_raw};
  end

  // Count consecutive cycles the synchronized level differs from the accepted
  // level; any bounce back restarts the count. Only accepted rises pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
      press   <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
        level_q <= sync_q[1];
        cnt_q   <= '0;
        press   <= sync_q[1];
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/clock_adjust_controller.sv
// Time-setting sequencer: debounced buttons drive a set-mode FSM that edits a
// BCD shadow of the time and loads it back into the counter on exit.
module clock_adjust_controller
  import wall_clock_pkg::*;
#(
  parameter int CLK_RATE_HZ = 100_000_000,
  parameter int DEBOUNCE_MS = 10,
  parameter int BLINK_HZ    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        adjustment_next,
  input  logic        adjustment_increment,
  input  logic [23:0] time_in,
  output logic        run_enable,
  output logic        time_load,
  output logic [23:0] time_load_value,
  output logic [23:0] display_data,
  output logic [5:0]  digit_enable_mask,
  output logic [1:0]  mode
);

  localparam int DEBOUNCE_CYCLES = CLK_RATE_HZ / 1000 * DEBOUNCE_MS;
  localparam int BLINK_HALF      = CLK_RATE_HZ / (2 * BLINK_HZ);
  localparam int BW              = $clog2(BLINK_HALF + 1);

  mode_e          state_q;
  logic [23:0]    shadow_q;
  logic [23:0]    shadow_inc;
  logic [BW-1:0]  blink_cnt_q;
  logic           blink_vis_q;
  logic           next_press;
  logic           inc_press;
  logic           inc_take;

  button_debouncer #(.STABLE_CYCLES(DEBOUNCE_CYCLES)) u_next_db (
    .clk        (clk),
    .reset_n    (reset_n),
    .button_raw (adjustment_next),
    .press      (next_press)
  );

  button_debouncer #(.STABLE_CYCLES(DEBOUNCE_CYCLES)) u_inc_db (
    .clk        (clk),
    .reset_n    (reset_n),
    .button_raw (adjustment_increment),
    .press      (inc_press)
  );

  // Advance a two-digit BCD field with wrap at lim. Out-of-range captured
  // values wrap to 00 so the shadow only ever receives valid BCD.
  function automatic logic [7:0] bcd_field_inc(input logic [7:0] f, input logic [7:0] lim);
    if (f >= lim)             return 8'h00;
    else if (f[3:0] >= 4'd9)  return {f[7:4] + 4'd1, 4'd0};
    else                      return {f[7:4], f[3:0] + 4'd1};
  endfunction

  // Increment applies only when not in RUN and no next press (next wins).
  assign inc_take = inc_press && !next_press && (state_q != MODE_RUN);

  // Shadow word with the currently selected field advanced.
  always_comb begin
    shadow_inc = shadow_q;
    case (state_q)
      MODE_SET_H: shadow_inc[HOURS_LSB   +: 8] = bcd_field_inc(shadow_q[HOURS_LSB   +: 8], HOURS_MAX_BCD);
      MODE_SET_M: shadow_inc[MINUTES_LSB +: 8] = bcd_field_inc(shadow_q[MINUTES_LSB +: 8], MIN_SEC_MAX_BCD);
      MODE_SET_S: shadow_inc[SECONDS_LSB +: 8] = bcd_field_inc(shadow_q[SECONDS_LSB +: 8], MIN_SEC_MAX_BCD);
      default:    shadow_inc = shadow_q;
    endcase
  end

  // Set-mode FSM with registered run-enable, load strobe and load value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= MODE_RUN;
      shadow_q        <= '0;
      run_enable      <= 1'b1;
      time_load       <= 1'b0;
      time_load_value <= '0;
    end else begin
      time_load <= 1'b0;
      if (next_press) begin
        case (state_q)
          MODE_RUN: begin
            shadow_q   <= time_in;
            run_enable <= 1'b0;
            state_q    <= MODE_SET_H;
          end
          MODE_SET_H: state_q <= MODE_SET_M;
          MODE_SET_M: state_q <= MODE_SET_S;
          MODE_SET_S: begin
            time_load_value <= shadow_q;
            time_load       <= 1'b1;
            run_enable      <= 1'b1;
            state_q         <= MODE_RUN;
          end
          default: state_q <= MODE_RUN;
        endcase
      end else if (inc_take) begin
        shadow_q <= shadow_inc;
      end
    end
  end

  // Blink phase: restart visible on any state change or edit so the new
  // value shows at once; idle-cleared while running.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt_q <= '0;
      blink_vis_q <= 1'b1;
    end else if (next_press || inc_take || state_q == MODE_RUN) begin
      blink_cnt_q <= '0;
      blink_vis_q <= 1'b1;
    end else if (blink_cnt_q == BW'(BLINK_HALF - 1)) begin
      blink_cnt_q <= '0;
      blink_vis_q <= ~blink_vis_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + BW'(1);
    end
  end

  // Blank the two digits of the field being edited during the off phase.
  always_comb begin
    digit_enable_mask = 6'b111111;
    if (!blink_vis_q) begin
      case (state_q)
        MODE_SET_H: digit_enable_mask[5:4] = 2'b00;
        MODE_SET_M: digit_enable_mask[3:2] = 2'b00;
        MODE_SET_S: digit_enable_mask[1:0] = 2'b00;
        default:    digit_enable_mask = 6'b111111;
      endcase
    end
  end

  assign mode         = state_q;
  assign display_data = (state_q == MODE_RUN) ? time_in : shadow_q;

endmodule
